// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared types for the rv32i pipeline hazard controller.
//   - hz_state_t      : sequencer state (RUN / MEM_WAIT)
//   - ex_rsmux_sel_t  : EX operand mux select (ID/EX, EX/MEM, MEM/WB)
//   - mem_rsmux_sel_t : MEM store-data mux select (EX/MEM, MEM/WB)
//   - X0              : index of the hard-wired zero register
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    typedef enum logic [1:0] {
        RS_ID_EX  = 2'd0,
        RS_EX_MEM = 2'd1,
        RS_MEM_WB = 2'd2
    } ex_rsmux_sel_t;

    typedef enum logic {
        MRS_EX_MEM = 1'b0,
        MRS_MEM_WB = 1'b1
    } mem_rsmux_sel_t;

    localparam logic [4:0] X0 = 5'd0;

endpackage : hazard_pkg

// File: rtl/hazard_ctrl_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
//   Combinational operand forwarding selects for the EX stage and the
//   store-data select for the MEM stage. Zero latency, no state.
// Ports
//   idex_rs1_i/idex_rs2_i  in   source registers of the instruction in EX
//   exmem_rd_i             in   destination in EX/MEM
//   exmem_regwrite_i       in   EX/MEM writes rd
//   exmem_load_i           in   EX/MEM is a load (its result is not ready yet)
//   exmem_rs2_i            in   store-data source of the instruction in MEM
//   memwb_rd_i             in   destination in MEM/WB
//   memwb_regwrite_i       in   MEM/WB writes rd
//   rs1_sel_o/rs2_sel_o    out  EX operand mux selects
//   mem_rs2_sel_o          out  MEM store-data mux select
// ---------------------------------------------------------------------------
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0] idex_rs1_i,
    input  logic [REG_IDX_W-1:0] idex_rs2_i,
    input  logic [REG_IDX_W-1:0] exmem_rd_i,
    input  logic                 exmem_regwrite_i,
    input  logic                 exmem_load_i,
    input  logic [REG_IDX_W-1:0] exmem_rs2_i,
    input  logic [REG_IDX_W-1:0] memwb_rd_i,
    input  logic                 memwb_regwrite_i,
    output ex_rsmux_sel_t        rs1_sel_o,
    output ex_rsmux_sel_t        rs2_sel_o,
    output mem_rsmux_sel_t       mem_rs2_sel_o
);

    localparam logic [REG_IDX_W-1:0] RD_X0 = REG_IDX_W'(X0);

    // A load in EX/MEM has no data yet; the load-use bubble covers that case.
    logic ex_fwd_ok;
    logic wb_fwd_ok;

    assign ex_fwd_ok = exmem_regwrite_i && !exmem_load_i && (exmem_rd_i != RD_X0);
    assign wb_fwd_ok = memwb_regwrite_i && (memwb_rd_i != RD_X0);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rs1_sel_o = RS_ID_EX;
        if (ex_fwd_ok && (exmem_rd_i == idex_rs1_i)) begin
            rs1_sel_o = RS_EX_MEM;   // youngest producer wins
        end else if (wb_fwd_ok && (memwb_rd_i == idex_rs1_i)) begin
            rs1_sel_o = RS_MEM_WB;
        end
    end

    always_comb begin
        rs2_sel_o = RS_ID_EX;
        if (ex_fwd_ok && (exmem_rd_i == idex_rs2_i)) begin
            rs2_sel_o = RS_EX_MEM;
        end else if (wb_fwd_ok && (memwb_rd_i == idex_rs2_i)) begin
            rs2_sel_o = RS_MEM_WB;
        end
    end

    always_comb begin
        mem_rs2_sel_o = MRS_EX_MEM;
        if (wb_fwd_ok && (memwb_rd_i == exmem_rs2_i)) begin
            mem_rs2_sel_o = MRS_MEM_WB;
        end
    end

endmodule : fwd_unit

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for the 5-stage rv32i core. Produces forwarding
//   selects, per-stage load/flush controls for load-use bubbles, taken-branch
//   flushes and instruction/data memory-wait freezes. Holds no datapath data.
//
//   Optional feature macro: HAZARD_PERF_EN
//     defined   : stall/flush/bubble counters built (saturating)
//     undefined : counters not built, outputs tied to zero
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_rs1/2 sources of the ID instruction and use flags
//   idex_rs1/rs2/rd/regwrite/load   ID/EX fields
//   exmem_rd/regwrite/load/rs2  EX/MEM fields
//   memwb_rd/regwrite           MEM/WB fields
//   br_taken                    EX redirect
//   imem_read/imem_resp         fetch request / 1-cycle completion pulse
//   dmem_req/dmem_resp          data request / 1-cycle completion pulse
//   imem_read_gate, dmem_req_gate   requests qualified against completed sides
//   rs1_sel/rs2_sel, mem_rs2_sel    forwarding mux selects
//   pc_load .. mem_wb_load      per-stage register load enables
//   if_id_flush, id_ex_flush    load a NOP into that register
//   stall_cnt/flush_cnt/bubble_cnt  performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_IDX_W = 5,
    parameter int PERF_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] idex_rs1,
    input  logic [REG_IDX_W-1:0] idex_rs2,
    input  logic [REG_IDX_W-1:0] idex_rd,
    input  logic                 idex_regwrite,
    input  logic                 idex_load,
    input  logic [REG_IDX_W-1:0] exmem_rd,
    input  logic                 exmem_regwrite,
    input  logic                 exmem_load,
    input  logic [REG_IDX_W-1:0] exmem_rs2,
    input  logic [REG_IDX_W-1:0] memwb_rd,
    input  logic                 memwb_regwrite,
    input  logic                 br_taken,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    output logic                 imem_read_gate,
    output logic                 dmem_req_gate,
    output ex_rsmux_sel_t        rs1_sel,
    output ex_rsmux_sel_t        rs2_sel,
    output mem_rsmux_sel_t       mem_rs2_sel,
    output logic                 pc_load,
    output logic                 if_id_load,
    output logic                 id_ex_load,
    output logic                 ex_mem_load,
    output logic                 mem_wb_load,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic [PERF_W-1:0]    stall_cnt,
    output logic [PERF_W-1:0]    flush_cnt,
    output logic [PERF_W-1:0]    bubble_cnt
);

    localparam logic [REG_IDX_W-1:0] RD_X0 = REG_IDX_W'(X0);

    // ---------------------------------------------------------------- forwarding
    ex_rsmux_sel_t  fwd_rs1;
    ex_rsmux_sel_t  fwd_rs2;
    mem_rsmux_sel_t fwd_mem_rs2;

    fwd_unit #(.REG_IDX_W(REG_IDX_W)) u_fwd (
        .idex_rs1_i       (idex_rs1),
        .idex_rs2_i       (idex_rs2),
        .exmem_rd_i       (exmem_rd),
        .exmem_regwrite_i (exmem_regwrite),
        .exmem_load_i     (exmem_load),
        .exmem_rs2_i      (exmem_rs2),
        .memwb_rd_i       (memwb_rd),
        .memwb_regwrite_i (memwb_regwrite),
        .rs1_sel_o        (fwd_rs1),
        .rs2_sel_o        (fwd_rs2),
        .mem_rs2_sel_o    (fwd_mem_rs2)
    );

    assign rs1_sel     = rst ? RS_ID_EX   : fwd_rs1;
    assign rs2_sel     = rst ? RS_ID_EX   : fwd_rs2;
    assign mem_rs2_sel = rst ? MRS_EX_MEM : fwd_mem_rs2;

    // ---------------------------------------------------------------- hazards
    hz_state_t state_q, state_d;
    logic      imem_done_q, imem_done_d;
    logic      dmem_done_q, dmem_done_d;

    logic load_use;
    logic imem_ok;
    logic dmem_ok;
    logic frozen;

    assign load_use = idex_load && idex_regwrite && (idex_rd != RD_X0) &&
                      ((id_use_rs1 && (id_rs1 == idex_rd)) ||
                       (id_use_rs2 && (id_rs2 == idex_rd)));

    // A side is satisfied if nothing is requested, it completes now, or it
    // completed earlier in this freeze. Flags are always clear in RUN, so the
    // same expression is the RUN-state wait condition.
    assign imem_ok = !imem_read || imem_resp || imem_done_q;
    assign dmem_ok = !dmem_req  || dmem_resp || dmem_done_q;
    assign frozen  = !(imem_ok && dmem_ok);

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

    // Next-state logic. Done flags are sticky within one freeze so responses
    // landing in different cycles are both remembered.
    always_comb begin
        state_d     = state_q;
        imem_done_d = imem_done_q;
        dmem_done_d = dmem_done_q;
        unique case (state_q)
            RUN: begin
                if (frozen) begin
                    state_d     = MEM_WAIT;
                    imem_done_d = imem_read && imem_resp;
                    dmem_done_d = dmem_req  && dmem_resp;
                end
            end
            MEM_WAIT: begin
                if (frozen) begin
                    imem_done_d = imem_done_q || (imem_read && imem_resp);
                    dmem_done_d = dmem_done_q || (dmem_req  && dmem_resp);
                end else begin
                    state_d     = RUN;
                    imem_done_d = 1'b0;
                    dmem_done_d = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Output logic. A branch held in EX through a freeze is acted on in the
    // release cycle because it falls through the same not-frozen path.
    always_comb begin
        pc_load        = 1'b0;
        if_id_load     = 1'b0;
        id_ex_load     = 1'b0;
        ex_mem_load    = 1'b0;
        mem_wb_load    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        imem_read_gate = 1'b0;
        dmem_req_gate  = 1'b0;
        if (rst) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            // Do not re-issue a side that already completed in this freeze.
            imem_read_gate = imem_read && !imem_done_q;
            dmem_req_gate  = dmem_req  && !dmem_done_q;
            if (!frozen) begin
                pc_load     = 1'b1;
                if_id_load  = 1'b1;
                id_ex_load  = 1'b1;
                ex_mem_load = 1'b1;
                mem_wb_load = 1'b1;
                if (br_taken) begin
                    // Wrong-path instructions in IF/ID and ID/EX are squashed;
                    // any load-use hit among them is moot.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, send a bubble down into EX.
                    pc_load     = 1'b0;
                    if_id_load  = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- counters
`ifdef HAZARD_PERF_EN
    logic               stall_inc;
    logic               flush_inc;
    logic               bubble_inc;
    logic [PERF_W-1:0]  stall_cnt_q;
    logic [PERF_W-1:0]  flush_cnt_q;
    logic [PERF_W-1:0]  bubble_cnt_q;

    assign stall_inc  = !rst && frozen;
    assign flush_inc  = !rst && !frozen && br_taken;
    assign bubble_inc = !rst && !frozen && !br_taken && load_use;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall_inc  && (stall_cnt_q  != '1)) stall_cnt_q  <= stall_cnt_q  + 1'b1;
            if (flush_inc  && (flush_cnt_q  != '1)) flush_cnt_q  <= flush_cnt_q  + 1'b1;
            if (bubble_inc && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed self-checking bench for hazard_ctrl. Inputs change just after
//   the falling edge and outputs are sampled 1 ns later, well away from the
//   rising edge. Expected counter values follow HAZARD_PERF_EN.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
    import hazard_pkg::*;

`ifdef HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd;
    logic [4:0]  exmem_rd, exmem_rs2, memwb_rd;
    logic        id_use_rs1, id_use_rs2, idex_regwrite, idex_load;
    logic        exmem_regwrite, exmem_load, memwb_regwrite;
    logic        br_taken, imem_read, imem_resp, dmem_req, dmem_resp;
    logic        imem_read_gate, dmem_req_gate;
    ex_rsmux_sel_t  rs1_sel, rs2_sel;
    mem_rsmux_sel_t mem_rs2_sel;
    logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_flush, id_ex_flush;
    logic [31:0] stall_cnt, flush_cnt, bubble_cnt;

    int checks = 0;
    int errors = 0;

    wire [4:0] loads   = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load};
    wire [1:0] flushes = {if_id_flush, id_ex_flush};
    wire [1:0] gates   = {imem_read_gate, dmem_req_gate};

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_IDX_W(5), .PERF_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .idex_rs1       (idex_rs1),
        .idex_rs2       (idex_rs2),
        .idex_rd        (idex_rd),
        .idex_regwrite  (idex_regwrite),
        .idex_load      (idex_load),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_load     (exmem_load),
        .exmem_rs2      (exmem_rs2),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .br_taken       (br_taken),
        .imem_read      (imem_read),
        .imem_resp      (imem_resp),
        .dmem_req       (dmem_req),
        .dmem_resp      (dmem_resp),
        .imem_read_gate (imem_read_gate),
        .dmem_req_gate  (dmem_req_gate),
        .rs1_sel        (rs1_sel),
        .rs2_sel        (rs2_sel),
        .mem_rs2_sel    (mem_rs2_sel),
        .pc_load        (pc_load),
        .if_id_load     (if_id_load),
        .id_ex_load     (id_ex_load),
        .ex_mem_load    (ex_mem_load),
        .mem_wb_load    (mem_wb_load),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .bubble_cnt     (bubble_cnt)
    );

    // Quiet pipeline: no hazards, no requests.
    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0; idex_regwrite = 0; idex_load = 0;
        exmem_rd = 0; exmem_regwrite = 0; exmem_load = 0; exmem_rs2 = 0;
        memwb_rd = 0; memwb_regwrite = 0;
        br_taken = 0; imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    endtask

    // Move to the next cycle's input window.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        exmem_regwrite = 1; exmem_rd = 5'd5; idex_rs1 = 5'd5;
        imem_read = 1; dmem_req = 1;
        next_cycle(); next_cycle();
        #1;
        checks++;
        if (loads !== 5'b00000) begin
            $display("FAIL reset_loads got %b exp %b", loads, 5'b00000); errors++;
        end
        checks++;
        if (flushes !== 2'b11) begin
            $display("FAIL reset_flushes got %b exp %b", flushes, 2'b11); errors++;
        end
        checks++;
        if (gates !== 2'b00) begin
            $display("FAIL reset_gates got %b exp %b", gates, 2'b00); errors++;
        end
        checks++;
        if (rs1_sel !== RS_ID_EX) begin
            $display("FAIL reset_rs1_sel got %0d exp %0d", rs1_sel, RS_ID_EX); errors++;
        end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            $display("FAIL reset_counters got %0d/%0d/%0d exp 0/0/0",
                     stall_cnt, flush_cnt, bubble_cnt); errors++;
        end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_forwarding();
        // add x5 in EX/MEM, EX reads x5 as rs1.
        next_cycle();
        idle_inputs();
        exmem_regwrite = 1; exmem_rd = 5'd5; idex_rs1 = 5'd5; idex_rs2 = 5'd3;
        #1;
        checks++;
        if (rs1_sel !== RS_EX_MEM) begin
            $display("FAIL fwd_exmem_rs1 got %0d exp %0d", rs1_sel, RS_EX_MEM); errors++;
        end
        checks++;
        if (rs2_sel !== RS_ID_EX) begin
            $display("FAIL fwd_nomatch_rs2 got %0d exp %0d", rs2_sel, RS_ID_EX); errors++;
        end
        checks++;
        if (loads !== 5'b11111 || flushes !== 2'b00) begin
            $display("FAIL fwd_quiet_ctrl got %b/%b exp 11111/00", loads, flushes); errors++;
        end
        // Same rd also in MEM/WB: EX/MEM still wins.
        next_cycle();
        memwb_regwrite = 1; memwb_rd = 5'd5;
        #1;
        checks++;
        if (rs1_sel !== RS_EX_MEM) begin
            $display("FAIL fwd_priority got %0d exp %0d", rs1_sel, RS_EX_MEM); errors++;
        end
        // Writes to x0 never forward.
        next_cycle();
        exmem_rd = 5'd0; memwb_rd = 5'd0; idex_rs1 = 5'd0;
        #1;
        checks++;
        if (rs1_sel !== RS_ID_EX) begin
            $display("FAIL fwd_x0 got %0d exp %0d", rs1_sel, RS_ID_EX); errors++;
        end
        // A load in EX/MEM is skipped; MEM/WB match on rs2 is used instead.
        next_cycle();
        exmem_load = 1; exmem_rd = 5'd9; memwb_rd = 5'd9; idex_rs2 = 5'd9;
        #1;
        checks++;
        if (rs2_sel !== RS_MEM_WB) begin
            $display("FAIL fwd_skip_load got %0d exp %0d", rs2_sel, RS_MEM_WB); errors++;
        end
    endtask

    task automatic test_load_use();
        // lw x6 in ID/EX, ID reads x6 only if use flag is set.
        next_cycle();
        idle_inputs();
        idex_load = 1; idex_regwrite = 1; idex_rd = 5'd6; id_rs1 = 5'd6;
        #1;
        checks++;
        if (loads !== 5'b11111 || flushes !== 2'b00) begin
            $display("FAIL lu_unused_src got %b/%b exp 11111/00", loads, flushes); errors++;
        end
        next_cycle();
        id_use_rs1 = 1;
        #1;
        checks++;
        if (loads !== 5'b00111 || flushes !== 2'b01) begin
            $display("FAIL lu_bubble got %b/%b exp 00111/01", loads, flushes); errors++;
        end
        // Bubble now in ID/EX, load in EX/MEM: no further stall.
        next_cycle();
        idle_inputs();
        id_rs1 = 5'd6; id_use_rs1 = 1;
        exmem_rd = 5'd6; exmem_regwrite = 1; exmem_load = 1;
        #1;
        checks++;
        if (loads !== 5'b11111 || flushes !== 2'b00) begin
            $display("FAIL lu_release got %b/%b exp 11111/00", loads, flushes); errors++;
        end
        checks++;
        if (bubble_cnt !== 32'(PERF)) begin
            $display("FAIL lu_bubble_cnt got %0d exp %0d", bubble_cnt, PERF); errors++;
        end
        // Dependent instruction now in EX, load in MEM/WB.
        next_cycle();
        idle_inputs();
        idex_rs1 = 5'd6; memwb_rd = 5'd6; memwb_regwrite = 1;
        #1;
        checks++;
        if (rs1_sel !== RS_MEM_WB) begin
            $display("FAIL lu_fwd_memwb got %0d exp %0d", rs1_sel, RS_MEM_WB); errors++;
        end
        // x0 destination never stalls.
        next_cycle();
        idle_inputs();
        idex_load = 1; idex_regwrite = 1; idex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1;
        #1;
        checks++;
        if (loads !== 5'b11111) begin
            $display("FAIL lu_x0 got %b exp 11111", loads); errors++;
        end
    endtask

    task automatic test_branch_priority();
        next_cycle();
        idle_inputs();
        idex_load = 1; idex_regwrite = 1; idex_rd = 5'd8; id_rs2 = 5'd8; id_use_rs2 = 1;
        br_taken = 1;
        #1;
        checks++;
        if (loads !== 5'b11111 || flushes !== 2'b11) begin
            $display("FAIL br_over_lu got %b/%b exp 11111/11", loads, flushes); errors++;
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (flush_cnt !== 32'(PERF) || bubble_cnt !== 32'(PERF)) begin
            $display("FAIL br_counters got flush %0d bubble %0d exp %0d %0d",
                     flush_cnt, bubble_cnt, PERF, PERF); errors++;
        end
    endtask

    task automatic test_mem_wait();
        // Expected per cycle 0..5: loads 0 until release at 5; fetch gate
        // drops after the imem response in cycle 2. Branch held throughout.
        logic [4:0] exp_loads [6];
        logic [1:0] exp_flush [6];
        logic       exp_igate [6];
        exp_loads = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11111};
        exp_flush = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
        exp_igate = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            idle_inputs();
            imem_read = 1; dmem_req = 1; br_taken = 1;
            imem_resp = (c == 2);
            dmem_resp = (c == 5);
            #1;
            checks++;
            if (loads !== exp_loads[c] || flushes !== exp_flush[c]) begin
                $display("FAIL mw_ctrl_c%0d got %b/%b exp %b/%b",
                         c, loads, flushes, exp_loads[c], exp_flush[c]); errors++;
            end
            checks++;
            if (gates !== {exp_igate[c], 1'b1}) begin
                $display("FAIL mw_gates_c%0d got %b exp %b", c, gates, {exp_igate[c], 1'b1}); errors++;
            end
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 32'(5 * PERF) || flush_cnt !== 32'(2 * PERF)) begin
            $display("FAIL mw_counters got stall %0d flush %0d exp %0d %0d",
                     stall_cnt, flush_cnt, 5 * PERF, 2 * PERF); errors++;
        end
        checks++;
        if (loads !== 5'b11111 || gates !== 2'b00) begin
            $display("FAIL mw_after got %b/%b exp 11111/00", loads, gates); errors++;
        end
    endtask

    task automatic test_store_fwd();
        next_cycle();
        idle_inputs();
        memwb_regwrite = 1; memwb_rd = 5'd7; exmem_rs2 = 5'd7;
        #1;
        checks++;
        if (mem_rs2_sel !== MRS_MEM_WB) begin
            $display("FAIL st_fwd got %0d exp %0d", mem_rs2_sel, MRS_MEM_WB); errors++;
        end
        next_cycle();
        memwb_rd = 5'd0; exmem_rs2 = 5'd0;
        #1;
        checks++;
        if (mem_rs2_sel !== MRS_EX_MEM) begin
            $display("FAIL st_x0 got %0d exp %0d", mem_rs2_sel, MRS_EX_MEM); errors++;
        end
        next_cycle();
        memwb_regwrite = 0; memwb_rd = 5'd7; exmem_rs2 = 5'd7;
        #1;
        checks++;
        if (mem_rs2_sel !== MRS_EX_MEM) begin
            $display("FAIL st_nowrite got %0d exp %0d", mem_rs2_sel, MRS_EX_MEM); errors++;
        end
    endtask

    task automatic test_reset_in_wait();
        // Cycle 0: data completes, fetch pending -> MEM_WAIT with dmem_done.
        next_cycle();
        idle_inputs();
        imem_read = 1; dmem_req = 1; dmem_resp = 1;
        #1;
        checks++;
        if (loads !== 5'b00000) begin
            $display("FAIL rw_enter got %b exp 00000", loads); errors++;
        end
        // Cycle 1: completed data side is no longer issued.
        next_cycle();
        dmem_resp = 0;
        #1;
        checks++;
        if (gates !== 2'b10) begin
            $display("FAIL rw_done_gate got %b exp 10", gates); errors++;
        end
        // Cycle 2: reset in the middle of the wait.
        next_cycle();
        rst = 1;
        #1;
        checks++;
        if (loads !== 5'b00000 || flushes !== 2'b11) begin
            $display("FAIL rw_rst got %b/%b exp 00000/11", loads, flushes); errors++;
        end
        // Cycle 3: back in RUN with flags clear; a pending data request
        // is issued again and freezes per RUN rules.
        next_cycle();
        rst = 0;
        imem_read = 0; dmem_req = 1;
        #1;
        checks++;
        if (gates !== 2'b01 || loads !== 5'b00000) begin
            $display("FAIL rw_run got %b/%b exp 01/00000", gates, loads); errors++;
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            $display("FAIL rw_cnt_clear got %0d exp 0", stall_cnt); errors++;
        end
        // Cycle 4: response releases.
        next_cycle();
        dmem_resp = 1;
        #1;
        checks++;
        if (loads !== 5'b11111) begin
            $display("FAIL rw_release got %b exp 11111", loads); errors++;
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_store_fwd();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_ctrl
